// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: NOP encoding, major opcodes, instruction field slices
// and the IF/ID payload layout used by fetch and decode.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  // Field LSB positions; widths are fixed by the ISA.
  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

  function automatic logic [6:0] opc_of(input logic [31:0] i);
    return i[OPC_LSB +: 7];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] i);
    return i[RD_LSB +: 5];
  endfunction

  function automatic logic [2:0] f3_of(input logic [31:0] i);
    return i[F3_LSB +: 3];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] i);
    return i[RS1_LSB +: 5];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] i);
    return i[RS2_LSB +: 5];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats bubble, otherwise load.
// Same control shape as the ID/EX register.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  if_id_t q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q.valid    <= 1'b0;
      q.instr    <= NOP_INSTR;
      q.pc       <= '0;
      q.pc_plus4 <= '0;
    end else if (flush_i) begin
      q.valid    <= 1'b0;
      q.instr    <= NOP_INSTR;
      q.pc       <= '0;
      q.pc_plus4 <= '0;
    end else if (hold_i) begin
      q <= q;
    end else if (bubble_i) begin
      // pc fields are left alone; the slot is marked empty.
      q.valid <= 1'b0;
      q.instr <= NOP_INSTR;
    end else begin
      q.valid    <= 1'b1;
      q.instr    <= instr_i;
      q.pc       <= pc_i;
      q.pc_plus4 <= pc_plus4_i;
    end
  end

  assign valid_o    = q.valid;
  assign instr_o    = q.instr;
  assign pc_o       = q.pc;
  assign pc_plus4_o = q.pc_plus4;

endmodule

// File: rtl/if_stage.sv
// RV32I instruction fetch: PC register, next-PC selection against a 1-cycle
// synchronous imem, and the IF/ID register with pre-split fields for decode.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirectPC_i,
  output logic [31:0] imemAddr_o,
  input  logic [31:0] imemRdata_i,
  output logic        valid_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [24:0] Instr31_7_o,
  output logic [6:0]  op_o,
  output logic [2:0]  funct3_o,
  output logic [31:0] PC_o,
  output logic [31:0] pcPlus4_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        fetch_vld_q;
  logic [31:0] instr;

  assign pc_plus4 = pc_q + 32'd4;

  // Without fetch_vld_q the memory has not yet read pc_q, so pc must not advance.
  always_comb begin
    pc_next = pc_plus4;
    if (redirect_i)                     pc_next = redirectPC_i;
    else if (stall_i || !fetch_vld_q)   pc_next = pc_q;
  end

  assign imemAddr_o = pc_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q        <= RESET_PC;
      fetch_vld_q <= 1'b0;
    end else begin
      pc_q        <= pc_next;
      fetch_vld_q <= 1'b1;
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (redirect_i),
    .hold_i     (stall_i),
    .bubble_i   (!fetch_vld_q),
    .instr_i    (imemRdata_i),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .valid_o    (valid_o),
    .instr_o    (instr),
    .pc_o       (PC_o),
    .pc_plus4_o (pcPlus4_o)
  );

  assign op_o        = opc_of(instr);
  assign rd_o        = rd_of(instr);
  assign funct3_o    = f3_of(instr);
  assign rs1_o       = rs1_of(instr);
  assign rs2_o       = rs2_of(instr);
  assign Instr31_7_o = instr[31:7];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a fetch-stream model checked every cycle plus
// hand-computed expectations for reset, stall, redirect, reset-mid-stall and wrap.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirectPC_i = '0;
  logic [31:0] imemAddr_o;
  logic [31:0] imemRdata_i = '0;
  logic        valid_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [24:0] Instr31_7_o;
  logic [6:0]  op_o;
  logic [2:0]  funct3_o;
  logic [31:0] PC_o, pcPlus4_o;

  int errors = 0;
  int checks = 0;

  if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirectPC_i (redirectPC_i),
    .imemAddr_o   (imemAddr_o),
    .imemRdata_i  (imemRdata_i),
    .valid_o      (valid_o),
    .rs1_o        (rs1_o),
    .rs2_o        (rs2_o),
    .rd_o         (rd_o),
    .Instr31_7_o  (Instr31_7_o),
    .op_o         (op_o),
    .funct3_o     (funct3_o),
    .PC_o         (PC_o),
    .pcPlus4_o    (pcPlus4_o)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous-read memory whose word at each address is the address itself.
  always @(posedge clk_i) imemRdata_i <= imemAddr_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the IF/ID slot contents plus the address of the next instruction
  // that will enter the slot, and whether a start-up bubble is still owed.
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_pc    = '0;
  logic [31:0] m_pp4   = '0;
  logic [31:0] m_fetch = RESET_PC;
  logic        m_warm  = 1'b1;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_valid = 1'b0; m_instr = NOP; m_pc = '0; m_pp4 = '0;
      m_fetch = RESET_PC; m_warm = 1'b1;
    end else if (redirect_i) begin
      m_valid = 1'b0; m_instr = NOP; m_pc = '0; m_pp4 = '0;
      m_fetch = redirectPC_i; m_warm = 1'b0;
    end else if (stall_i) begin
      m_warm = 1'b0;
    end else if (m_warm) begin
      m_valid = 1'b0; m_instr = NOP; m_warm = 1'b0;
    end else begin
      m_valid = 1'b1; m_instr = m_fetch; m_pc = m_fetch; m_pp4 = m_fetch + 32'd4;
      m_fetch = m_fetch + 32'd4;
    end
  end

  always @(negedge clk_i) begin
    logic [31:0] exp_addr;
    exp_addr = redirect_i ? redirectPC_i : ((stall_i || m_warm) ? m_fetch : m_fetch + 32'd4);
    chk("m_valid",   {31'd0, valid_o},        {31'd0, m_valid});
    chk("m_pc",      PC_o,                    m_pc);
    chk("m_pp4",     pcPlus4_o,               m_pp4);
    chk("m_op",      {25'd0, op_o},           {25'd0, m_instr[6:0]});
    chk("m_rd",      {27'd0, rd_o},           {27'd0, m_instr[11:7]});
    chk("m_f3",      {29'd0, funct3_o},       {29'd0, m_instr[14:12]});
    chk("m_rs1",     {27'd0, rs1_o},          {27'd0, m_instr[19:15]});
    chk("m_rs2",     {27'd0, rs2_o},          {27'd0, m_instr[24:20]});
    chk("m_i31_7",   {7'd0, Instr31_7_o},     {7'd0, m_instr[31:7]});
    chk("m_addr",    imemAddr_o,              exp_addr);
  end

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic look();
    @(negedge clk_i);
  endtask

  task automatic chk_slot(input string name, input logic v, input logic [31:0] pc);
    look();
    chk({name, "_valid"}, {31'd0, valid_o}, {31'd0, v});
    if (v) begin
      chk({name, "_pc"},  PC_o, pc);
      chk({name, "_pp4"}, pcPlus4_o, pc + 32'd4);
    end else begin
      chk({name, "_op"}, {25'd0, op_o}, 32'h13);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    step(); step();
    look();
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_op",    {25'd0, op_o}, 32'h13);
    chk("rst_rd",    {27'd0, rd_o}, 32'd0);
    chk("rst_i31_7", {7'd0, Instr31_7_o}, 32'd0);
    chk("rst_pc",    PC_o, 32'h0);
    chk("rst_pp4",   pcPlus4_o, 32'h0);
    step(); rst_ni = 1'b1;

    // 1: start-up bubble then sequential fetch
    step(); chk_slot("s1_c1", 1'b0, 32'h0);
    step(); chk_slot("s1_c2", 1'b1, 32'h0);
    step(); chk_slot("s1_c3", 1'b1, 32'h4);
    step(); chk_slot("s1_c4", 1'b1, 32'h8);

    // 2: stall three cycles holding PC 0x8
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_slot("s2_hold", 1'b1, 32'h8);
      chk("s2_addr", imemAddr_o, 32'hC);
    end
    stall_i = 1'b0;
    step(); chk_slot("s2_rel", 1'b1, 32'hC);
    step(); chk_slot("s2_nxt", 1'b1, 32'h10);

    // 3: redirect to 0x100
    redirect_i = 1'b1; redirectPC_i = 32'h100;
    look(); chk("s3_addr", imemAddr_o, 32'h100);
    step(); redirect_i = 1'b0; chk_slot("s3_flush", 1'b0, 32'h0);
    step(); chk_slot("s3_tgt", 1'b1, 32'h100);
    step(); chk_slot("s3_nxt", 1'b1, 32'h104);

    // 4: redirect and stall together
    redirect_i = 1'b1; stall_i = 1'b1; redirectPC_i = 32'h200;
    step(); redirect_i = 1'b0; stall_i = 1'b0; chk_slot("s4_flush", 1'b0, 32'h0);
    step(); chk_slot("s4_tgt", 1'b1, 32'h200);

    // 5: reset pulsed mid-stall
    stall_i = 1'b1;
    step(); chk_slot("s5_hold", 1'b1, 32'h200);
    step(); #2; rst_ni = 1'b0; #1;
    chk("s5_async_valid", {31'd0, valid_o}, 32'd0);
    chk("s5_async_pc",    PC_o, 32'h0);
    chk("s5_async_op",    {25'd0, op_o}, 32'h13);
    chk("s5_async_addr",  imemAddr_o, RESET_PC);
    step(); rst_ni = 1'b1; stall_i = 1'b0;
    step(); chk_slot("s5_bubble", 1'b0, 32'h0);
    step(); chk_slot("s5_first", 1'b1, RESET_PC);
    step(); chk_slot("s5_second", 1'b1, RESET_PC + 32'h4);

    // 6: redirect to top of address space, wrap to 0
    redirect_i = 1'b1; redirectPC_i = 32'hFFFF_FFFC;
    step(); redirect_i = 1'b0; chk_slot("s6_flush", 1'b0, 32'h0);
    step(); look();
    chk("s6_pc",  PC_o, 32'hFFFF_FFFC);
    chk("s6_pp4", pcPlus4_o, 32'h0);
    chk("s6_i31_7", {7'd0, Instr31_7_o}, 32'h01FF_FFFF);
    step(); chk_slot("s6_wrap", 1'b1, 32'h0);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
